// File: rtl/stb_drain_pkg.sv
// Shared constants and arbiter state encoding for the store-buffer drain arbiter.
package stb_drain_pkg;
  localparam int NTHR  = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int THR_W = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/stb_drain_arb_rr_pick4.sv
// Combinational round-robin picker: the first set request at or after ptr_i wins.
module rr_pick4 #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
        any_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stb_drain_arb.sv
// Per-thread store-buffer occupancy tracking and round-robin drain of unissued
// stores onto one shared issue port, with a sticky protocol-error flag.
module stb_drain_arb #(
  parameter int NTHR  = stb_drain_pkg::NTHR,
  parameter int DEPTH = stb_drain_pkg::DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  logic [NTHR-1:0]                      st_enq,
  input  logic [NTHR-1:0]                      st_ack,
  input  logic [NTHR-1:0]                      thr_flush,
  input  logic                                 pcx_gnt,
  output logic                                 pcx_req,
  output logic [stb_drain_pkg::THR_W-1:0]      pcx_thr,
  output logic [stb_drain_pkg::CNT_W*NTHR-1:0] stb_cnt,
  output logic [NTHR-1:0]                      stb_full,
  output logic                                 ovfl_err,
  output logic [stb_drain_pkg::THR_W-1:0]      err_thr
);
  import stb_drain_pkg::*;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [NTHR-1:0][CNT_W-1:0] cnt_q, cnt_d, pend_q, pend_d;
  arb_state_e                 state_q, state_d;
  logic [THR_W-1:0]           thr_q, thr_d, rr_q, rr_d, thr_inc;
  logic                       err_q, err_d;
  logic [THR_W-1:0]           err_thr_q, err_thr_d, err_low;

  logic [NTHR-1:0] enq_ok, ack_ok, err_v, gnt_t, elig_idle, elig_post, pk_req;
  logic [NTHR-1:0] pk_gnt;
  logic [THR_W-1:0] pk_ptr, pk_idx;
  logic             pk_any, gnt_fire;

  // A grant on a thread being flushed in the same cycle is discarded.
  assign gnt_fire = (state_q == S_REQ) && pcx_gnt && !thr_flush[thr_q];
  assign thr_inc  = (thr_q == THR_W'(NTHR-1)) ? '0 : thr_q + 1'b1;

  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      gnt_t[t]  = gnt_fire && (thr_q == THR_W'(t));
      ack_ok[t] = st_ack[t] && (cnt_q[t] != pend_q[t]);
      // A full buffer still accepts an enq when a valid ack frees a slot.
      enq_ok[t] = st_enq[t] && ((cnt_q[t] != DEPTH_C) || ack_ok[t]);
      err_v[t]  = !thr_flush[t] &&
                  ((st_enq[t] && !enq_ok[t]) || (st_ack[t] && !ack_ok[t]));
      if (thr_flush[t]) begin
        cnt_d[t]  = '0;
        pend_d[t] = '0;
      end else begin
        cnt_d[t]  = cnt_q[t] + CNT_W'(enq_ok[t]) - CNT_W'(ack_ok[t]);
        pend_d[t] = pend_q[t] + CNT_W'(enq_ok[t]) - CNT_W'(gnt_t[t]);
      end
      elig_idle[t] = (pend_q[t] != '0) && !thr_flush[t];
      elig_post[t] = ((pend_q[t] - CNT_W'(gnt_t[t])) != '0) && !thr_flush[t];
    end
  end

  // In REQ the picker only matters on a grant, where it looks past the granted thread.
  assign pk_req = (state_q == S_REQ) ? elig_post : elig_idle;
  assign pk_ptr = (state_q == S_REQ) ? thr_inc : rr_q;

  rr_pick4 #(.N(NTHR), .IW(THR_W)) u_pick (
    .req_i (pk_req),
    .ptr_i (pk_ptr),
    .gnt_o (pk_gnt),
    .idx_o (pk_idx),
    .any_o (pk_any)
  );

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (pk_any) begin
          state_d = S_REQ;
          thr_d   = pk_idx;
        end
      end
      S_REQ: begin
        if (thr_flush[thr_q]) begin
          state_d = S_IDLE;
        end else if (pcx_gnt) begin
          rr_d = thr_inc;
          if (pk_any) thr_d = pk_idx;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_low = '0;
    for (int t = NTHR-1; t >= 0; t--) begin
      if (err_v[t]) err_low = THR_W'(t);
    end
    err_d     = err_q | (|err_v);
    err_thr_d = (!err_q && (|err_v)) ? err_low : err_thr_q;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      state_q   <= S_IDLE;
      thr_q     <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
      err_thr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      thr_q     <= thr_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      err_thr_q <= err_thr_d;
    end
  end

  assign pcx_req  = (state_q == S_REQ);
  assign pcx_thr  = thr_q;
  assign ovfl_err = err_q;
  assign err_thr  = err_thr_q;

  for (genvar t = 0; t < NTHR; t++) begin : g_out
    assign stb_cnt[CNT_W*t +: CNT_W] = cnt_q[t];
    assign stb_full[t]               = (cnt_q[t] == DEPTH_C);
  end

  a_pick_onehot: assert property (@(posedge clk) disable iff (!rst_l)
    pk_any |-> (pk_gnt == (NTHR'(1) << pk_idx)));
  a_pend_le_cnt: assert property (@(posedge clk) disable iff (!rst_l)
    pend_q[thr_q] <= cnt_q[thr_q]);
endmodule

// File: doc/stb_drain_arb.md
STB_DRAIN_ARB -- requirements
Module: stb_drain_arb

Interface
REQ-001 Parameter NTHR, default 4: threads per core sharing one issue port.
REQ-002 Parameter DEPTH, default 8: store buffer entries per thread.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  core clock; single clock domain.
- rst_l  in  1  asynchronous, active-low reset.
- st_enq  in  NTHR  per-thread store written into buffer this cycle.
- st_ack  in  NTHR  per-thread issued store acknowledged; entry freed.
- thr_flush  in  NTHR  per-thread buffer reset.
- pcx_gnt  in  1  issue port accepts current request.
- pcx_req  out  1  issue request valid.
- pcx_thr  out  2  thread id of request.
- stb_cnt  out  4*NTHR  per-thread occupancy, thread t at [4t+3:4t].
- stb_full  out  NTHR  occupancy == DEPTH.
- ovfl_err  out  1  sticky protocol error.
- err_thr  out  2  thread of first error.

Function
REQ-004 Per thread, SHALL keep cnt (0..DEPTH, 4 bits) and pend (unissued, 0..cnt); issued-outstanding = cnt - pend.
REQ-005 st_enq[t] with cnt<DEPTH: cnt+1, pend+1, effective next cycle.
REQ-006 st_ack[t] with outstanding>0: cnt-1.
REQ-007 Simultaneous enq and ack on one thread: cnt unchanged; pend+1.
REQ-008 Enq at cnt==DEPTH without same-cycle ack: enq dropped, cnt stays DEPTH, error raised.
REQ-009 Ack with outstanding==0: ack ignored, error raised.
REQ-010 Error: ovfl_err set next cycle and held until reset; err_thr captures lowest-numbered erring thread of the first error cycle only.
REQ-011 thr_flush[t]: cnt and pend cleared next cycle; overrides same-cycle enq/ack on t; no error.
REQ-012 Arbiter FSM states: IDLE, REQ.
REQ-013 IDLE: if any pend>0 (flushing threads excluded), select by round-robin from rr_ptr, go REQ, assert pcx_req/pcx_thr next cycle; minimum enq-to-pcx_req latency 2 cycles.
REQ-014 REQ: pcx_req and pcx_thr SHALL hold stable until pcx_gnt, except flush of pcx_thr, which drops pcx_req next cycle and returns to IDLE.
REQ-015 On pcx_gnt in REQ: pend[pcx_thr]-1, rr_ptr = pcx_thr+1 mod NTHR.
REQ-016 On the same grant cycle, re-arbitrate against post-grant pend; if any thread is eligible, stay in REQ with the new thread (back-to-back, no bubble), else go IDLE.
REQ-017 Grant with same-cycle enq on the granted thread: pend net unchanged.
REQ-018 stb_full[t] and stb_cnt SHALL be registered-state outputs (no combinational path from inputs).

Reset
REQ-019 rst_l low SHALL asynchronously force: cnt=0, pend=0, rr_ptr=0, state IDLE, pcx_req=0, pcx_thr=0, stb_full=0, ovfl_err=0, err_thr=0.
REQ-020 Reset mid-request SHALL drop pcx_req immediately; any in-flight grant is discarded.

Structure
REQ-021 Package stb_drain_pkg SHALL hold NTHR, DEPTH, CNT_W=4, and the FSM state enum.
REQ-022 One sub-module, rr_pick4, SHALL be used: a combinational round-robin picker (request vector, pointer in; one-hot grant and index out).

Verification
REQ-023 3 enqs on T2, pcx_gnt tied 1 -> pcx_req high 2 cycles after first enq, three back-to-back grants to T2, stb_cnt T2=3 until acks.
REQ-024 1 pending store each on T0..T3, rr_ptr=0, gnt always 1 -> pcx_thr sequence 0,1,2,3; rr_ptr=0 afterward.
REQ-025 T1 filled to 8, 9th enq without ack -> cnt stays 8, stb_full[1]=1, ovfl_err=1, err_thr=1 next cycle.
REQ-026 T3 at cnt=8 with enq+ack same cycle -> cnt stays 8, no error.
REQ-027 T0 in REQ with gnt=0, thr_flush[0] -> pcx_req=0 next cycle, cnt T0=0, state IDLE.
REQ-028 rst_l asserted mid-REQ with pcx_gnt=1 -> all outputs 0 immediately; no pend decrement after release.
